// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding and default
// period/tolerance/lock/timeout constants.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } mon_state_t;

    localparam int DEF_EXP_PERIOD = 5;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TIMEOUT    = 20;

    // Lower tolerance bound, clamped at zero so unsigned compares stay valid.
    function automatic int tol_low(input int exp_period, input int tol);
        return (exp_period > tol) ? exp_period - tol : 0;
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control and status bundle between the divided-clock monitor (slave) and
// whatever drives/observes it (master).
interface clk_div_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             div_in;
    logic             mon_en;
    logic             clr_err;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output div_in, mon_en, clr_err,
        input  rise_pulse, period, period_vld, locked, err, err_cnt
    );

    modport slave (
        input  div_in, mon_en, clr_err,
        output rise_pulse, period, period_vld, locked, err, err_cnt
    );
endinterface

// File: rtl/edge_sync.sv
// Brings the divided clock into the clk domain as data and finds its rising
// edges; edge_det is the raw detect, rise is its registered copy.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_det,
    output logic rise
);
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= edge_det;
        end
    end

    assign edge_det = s2 & ~s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of the divided clock in clk cycles, declares lock after
// consecutive good periods and flags deviations and a stuck divided clock.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8
) (
    input logic         clk,
    input logic         rst,
    clk_div_monitor_if.slave mon
);
    localparam logic [CNT_W:0]   TOL_LO    = (CNT_W+1)'(tol_low(EXP_PERIOD, TOL));
    localparam logic [CNT_W:0]   TOL_HI    = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [7:0]       LOCK_C    = 8'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    logic             edge_det;
    logic             rise;
    mon_state_t       state;
    mon_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       match_cnt;
    logic [7:0]       match_next;
    logic             in_tol;
    logic             err_evt;
    logic             period_ld;
    logic [CNT_W-1:0] period_q;
    logic             period_vld_q;
    logic             locked_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (mon.div_in),
        .edge_det (edge_det),
        .rise     (rise)
    );

    // Acting on the raw detect lets period, period_vld and err register on the
    // same edge as rise_pulse, so period is already valid while period_vld is high.
    always_ff @(posedge clk) begin
        if (!rst || !mon.mon_en) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign in_tol = ({1'b0, cnt} >= TOL_LO) && ({1'b0, cnt} <= TOL_HI);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        match_next = match_cnt;
        err_evt    = 1'b0;
        period_ld  = 1'b0;
        if (!mon.mon_en) begin
            state_next = IDLE;
            match_next = '0;
        end else begin
            case (state)
                IDLE: state_next = ACQUIRE;
                ACQUIRE: begin
                    if (edge_det) begin
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        period_ld = 1'b1;
                        if (in_tol) begin
                            match_next = match_cnt + 8'd1;
                            if (match_cnt + 8'd1 >= LOCK_C) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            match_next = '0;
                            err_evt    = 1'b1;
                        end
                    end else if (cnt == TIMEOUT_C) begin
                        match_next = '0;
                        err_evt    = 1'b1;
                        state_next = ACQUIRE;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        period_ld = 1'b1;
                        if (!in_tol) begin
                            match_next = '0;
                            err_evt    = 1'b1;
                            state_next = MEASURE;
                        end
                    end else if (cnt == TIMEOUT_C) begin
                        match_next = '0;
                        err_evt    = 1'b1;
                        state_next = ACQUIRE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A clear coinciding with a new error keeps that error counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_cnt    <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            match_cnt    <= match_next;
            period_vld_q <= period_ld;
            locked_q     <= (state_next == LOCKED);
            err_q        <= err_evt;
            if (period_ld) begin
                period_q <= cnt;
            end
            if (mon.clr_err && err_evt) begin
                err_cnt_q <= ERR_W'(1);
            end else if (mon.clr_err) begin
                err_cnt_q <= '0;
            end else if (err_evt && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign mon.rise_pulse = rise;
    assign mon.period     = period_q;
    assign mon.period_vld = period_vld_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;
    assign mon.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a TOL=0 and a TOL=1 instance driven from
// a shared stimulus generator, with table-driven period vectors plus corner sequences.
module tb_clk_div_monitor;

    typedef struct {
        int p;
        int clr_tick;
        int exp_vld;
        int exp_period;
        int exp_err;
        int exp_locked;
        int exp_errcnt;
    } vec_t;

    logic clk;
    logic rst;
    logic sel;
    logic div_drv;
    logic en_drv;
    logic clr_drv;

    logic       s_vld;
    logic       s_err;
    logic       s_locked;
    logic       s_rise;
    logic [7:0] s_period;
    logic [7:0] s_errcnt;

    int total;
    int bad;
    int n_vld;
    int n_err;
    int n_rise;
    int last_period;
    int first_err;
    int sum_err;
    vec_t tbl[$];

    clk_div_monitor_if #(.CNT_W(8), .ERR_W(8)) if0 ();
    clk_div_monitor_if #(.CNT_W(8), .ERR_W(8)) if1 ();

    assign if0.div_in  = sel ? 1'b0 : div_drv;
    assign if0.mon_en  = sel ? 1'b0 : en_drv;
    assign if0.clr_err = sel ? 1'b0 : clr_drv;
    assign if1.div_in  = sel ? div_drv : 1'b0;
    assign if1.mon_en  = sel ? en_drv  : 1'b0;
    assign if1.clr_err = sel ? clr_drv : 1'b0;

    assign s_vld    = sel ? if1.period_vld : if0.period_vld;
    assign s_err    = sel ? if1.err        : if0.err;
    assign s_locked = sel ? if1.locked     : if0.locked;
    assign s_rise   = sel ? if1.rise_pulse : if0.rise_pulse;
    assign s_period = sel ? if1.period     : if0.period;
    assign s_errcnt = sel ? if1.err_cnt    : if0.err_cnt;

    clk_div_monitor #(
        .EXP_PERIOD(5), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(20), .CNT_W(8), .ERR_W(8)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .mon (if0.slave)
    );

    clk_div_monitor #(
        .EXP_PERIOD(5), .TOL(1), .LOCK_COUNT(4), .TIMEOUT(20), .CNT_W(8), .ERR_W(8)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .mon (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        if (s_vld) begin
            n_vld++;
            last_period = int'(s_period);
        end
        if (s_err) n_err++;
        if (s_rise) n_rise++;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One divided-clock period of p cycles (high p/2, then low); clr_err pulses
    // for one cycle after tick clr_tick when clr_tick is nonzero.
    task automatic applyStimulus(input int p, input int clr_tick);
        n_vld = 0;
        n_err = 0;
        n_rise = 0;
        last_period = 0;
        for (int i = 0; i < p; i++) begin
            div_drv = (i < p / 2);
            tick();
            sample();
            clr_drv = (i + 1 == clr_tick);
        end
        clr_drv = 1'b0;
    endtask

    function automatic void add(input int p, input int clr_tick, input int vld, input int per,
                                input int e, input int lk, input int ecnt);
        vec_t v;
        v.p = p;
        v.clr_tick = clr_tick;
        v.exp_vld = vld;
        v.exp_period = per;
        v.exp_err = e;
        v.exp_locked = lk;
        v.exp_errcnt = ecnt;
        tbl.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].p, tbl[i].clr_tick);
            checkOutput($sformatf("%s[%0d].rise", tag, i), n_rise, 1);
            checkOutput($sformatf("%s[%0d].vld", tag, i), n_vld, tbl[i].exp_vld);
            if (tbl[i].exp_vld != 0)
                checkOutput($sformatf("%s[%0d].period", tag, i), last_period, tbl[i].exp_period);
            checkOutput($sformatf("%s[%0d].err", tag, i), n_err, tbl[i].exp_err);
            checkOutput($sformatf("%s[%0d].locked", tag, i), int'(s_locked), tbl[i].exp_locked);
            if (tbl[i].exp_errcnt >= 0)
                checkOutput($sformatf("%s[%0d].errcnt", tag, i), int'(s_errcnt), tbl[i].exp_errcnt);
        end
        tbl.delete();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        sel = 1'b0;
        div_drv = 1'b0;
        en_drv = 1'b0;
        clr_drv = 1'b0;
        repeat (3) tick();

        checkOutput("reset.period", int'(s_period), 0);
        checkOutput("reset.vld", int'(s_vld), 0);
        checkOutput("reset.locked", int'(s_locked), 0);
        checkOutput("reset.err", int'(s_err), 0);
        checkOutput("reset.errcnt", int'(s_errcnt), 0);
        checkOutput("reset.rise", int'(s_rise), 0);
        rst = 1'b1;
        tick();

        // TOL=1 instance: 4,6,5,6 all accepted, lock on the 4th match, then 7 rejected
        $display("[TB] tolerance-1 instance");
        sel = 1'b1;
        en_drv = 1'b1;
        repeat (2) tick();
        add(4, 0, 0, 0, 0, 0, 0);
        add(6, 0, 1, 4, 0, 0, -1);
        add(5, 0, 1, 6, 0, 0, -1);
        add(6, 0, 1, 5, 0, 0, -1);
        add(7, 0, 1, 6, 0, 1, 0);
        add(5, 0, 1, 7, 1, 0, 1);
        run_table("tol1");

        // TOL=0 instance: acquire, lock, one stretched period, relock
        $display("[TB] lock and stretched period");
        sel = 1'b0;
        repeat (2) tick();
        add(5, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 1, 0);
        add(5, 0, 1, 5, 0, 1, 0);
        add(7, 0, 1, 5, 0, 1, 0);
        add(5, 0, 1, 7, 1, 0, 1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 1, 1);
        run_table("lock");

        // Stuck divided clock: exactly one timeout error, 20 cycles after the last edge
        $display("[TB] stuck divided clock");
        div_drv = 1'b0;
        n_err = 0;
        first_err = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (s_err) begin
                n_err++;
                if (first_err == 0) first_err = n;
            end
            if (n == 10) begin
                checkOutput("stuck.early_locked", int'(s_locked), 1);
                checkOutput("stuck.early_err", n_err, 0);
            end
        end
        checkOutput("stuck.err_pulses", n_err, 1);
        checkOutput("stuck.err_tick", first_err, 18);
        checkOutput("stuck.locked", int'(s_locked), 0);
        checkOutput("stuck.errcnt", int'(s_errcnt), 2);

        // Back in acquire: first edge gives no period, then matches build to 3
        add(5, 0, 0, 0, 0, 0, 2);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, 2);
        run_table("reacq");

        // Reset in the middle of a measurement
        $display("[TB] reset mid-measure");
        rst = 1'b0;
        repeat (2) tick();
        checkOutput("midrst.period", int'(s_period), 0);
        checkOutput("midrst.vld", int'(s_vld), 0);
        checkOutput("midrst.locked", int'(s_locked), 0);
        checkOutput("midrst.err", int'(s_err), 0);
        checkOutput("midrst.errcnt", int'(s_errcnt), 0);
        checkOutput("midrst.rise", int'(s_rise), 0);
        rst = 1'b1;
        tick();
        add(5, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 5, 0, 0, 0);
        run_table("postrst");

        // Error counter saturation with period-3 input
        $display("[TB] error counter saturation");
        sum_err = 0;
        for (int k = 0; k < 260; k++) begin
            applyStimulus(3, 0);
            sum_err += n_err;
        end
        checkOutput("sat.err_pulses", sum_err, 259);
        checkOutput("sat.errcnt", int'(s_errcnt), 255);
        add(3, 0, 1, 3, 1, 0, 255);
        add(3, 2, 1, 3, 1, 0, 1);
        run_table("sat");

        clr_drv = 1'b1;
        tick();
        clr_drv = 1'b0;
        tick();
        checkOutput("clr.errcnt", int'(s_errcnt), 0);

        // Relock, then disable: locked drops, period and err_cnt hold, no err
        $display("[TB] disable and re-enable");
        add(5, 0, 1, 5, 0, 0, 0);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 0, -1);
        add(5, 0, 1, 5, 0, 1, 0);
        run_table("relock");
        en_drv = 1'b0;
        n_vld = 0;
        n_err = 0;
        n_rise = 0;
        repeat (2) begin
            tick();
            sample();
        end
        checkOutput("dis.locked", int'(s_locked), 0);
        checkOutput("dis.period", int'(s_period), 5);
        checkOutput("dis.err", n_err, 0);
        checkOutput("dis.vld", n_vld, 0);
        en_drv = 1'b1;
        repeat (2) tick();
        add(5, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 5, 0, 0, 0);
        run_table("reen");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
